fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction fetch stage directly upstream of the decode/control unit.
- Holds the PC and issues one-outstanding-request reads to instruction memory.
- Presents the fetched instruction, its PC and its 7-bit opcode field to decode over a valid/ready handshake.
- Accepts branch/jump redirects from downstream and discards stale in-flight responses.

Parameters:
- XLEN, 32: PC and instruction width.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  request valid to instruction memory.
- imem_addr  out  XLEN  request address; always the current PC.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  XLEN  instruction word.
- redirect_valid  in  1  branch/jump taken; load a new PC.
- redirect_pc  in  XLEN  redirect target.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts the instruction.
- out_instr  out  XLEN  instruction word.
- out_opcode  out  7  out_instr[6:0], fed to control unit opcode.
- out_pc  out  XLEN  PC of out_instr.
- out_pc_plus4  out  XLEN  out_pc + 4, modulo 2^XLEN.

Behaviour:
- Reset (rst high at a clock edge):
  - pc <= RESET_PC, state <= FETCH, drop <= 0, out_valid <= 0.
  - out_instr, out_pc and out_pc_plus4 <= 0.
  - imem_req is forced to 0 while rst is high.
  - Reset mid-operation abandons any outstanding request; a later imem_rvalid is ignored because state is FETCH.
- FSM states: FETCH, WAIT, HOLD.
- FETCH:
  - imem_req = !redirect_valid; imem_addr = pc.
  - imem_req && imem_gnt -> WAIT.
  - No grant -> stay in FETCH; address is held stable.
- WAIT:
  - imem_req = 0. On imem_rvalid:
  - If drop = 1: drop <= 0, response discarded, -> FETCH.
  - Otherwise: out_instr <= imem_rdata, out_pc <= pc, out_pc_plus4 <= pc+4, pc <= pc+4, out_valid <= 1, -> HOLD.
- HOLD:
  - out_valid = 1, and all out_* signals are held stable.
  - out_ready -> out_valid <= 0, -> FETCH.
- Redirect (priority over every other event in every state):
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}; misaligned low bits are cleared.
  - FETCH: imem_req is suppressed this cycle; stay in FETCH; the next cycle requests the new PC.
  - WAIT without imem_rvalid: drop <= 1, stay in WAIT.
  - WAIT with imem_rvalid in the same cycle: response discarded, drop <= 0, -> FETCH.
  - HOLD: out_valid <= 0, -> FETCH; the held instruction is flushed even if out_ready is high.
- Latency and throughput:
  - Zero-wait memory (grant in FETCH, rvalid the following cycle): out_valid rises 2 cycles after the FETCH cycle begins.
  - Steady state with out_ready held high: one instruction every 3 cycles.
- out_opcode is combinational from out_instr[6:0].
- At most one outstanding memory request at any time.
- PC increment wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

Test Plan:
1. Reset release, zero-wait memory returning 32'h0000_0033 at 0x0, out_ready=1 -> imem_addr=0x0 in the first cycle after reset; out_valid=1 with out_pc=0x0, out_opcode=7'b0110011, out_pc_plus4=0x4; next imem_addr=0x4.
2. Backpressure: out_ready=0 for 5 cycles while holding instr 32'h00000013 -> out_valid stays 1 and out_instr is stable; imem_req=0 throughout; the PC 0x8 fetch starts the cycle after out_ready=1.
3. Redirect in WAIT to 0x100, rvalid arriving 2 cycles later with 32'hDEAD_BEEF -> that data is never presented; next imem_addr=0x100; out_pc=0x100 for the following instruction.
4. Redirect in HOLD with out_ready=1 in the same cycle, redirect_pc=0x203 -> held instruction flushed (out_valid 0 next cycle); imem_addr=0x200.
5. Grant stall: imem_gnt low for 3 cycles at pc=0x40 -> imem_req=1 and imem_addr=0x40 stable for all 4 cycles; exactly one response is consumed.
6. Wrap and reset: redirect to 0xFFFF_FFFC, fetch one instr -> out_pc_plus4=0x0 and next imem_addr=0x0; assert rst while in WAIT -> out_valid=0 and pc=RESET_PC; the late rvalid is ignored.

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage. Holds the PC, issues single-outstanding
//               reads to instruction memory and hands the fetched word, its PC
//               and its opcode field to decode over a valid/ready handshake.
//               Branch/jump redirects reload the PC and squash stale responses.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,

    // Instruction memory request/response
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,

    // Redirect from downstream (branch/jump taken)
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,

    // Decode-side handshake
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [6:0]      out_opcode,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_plus4
);

    // ------------------------------------------------------------------------
    // Types and constants
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,   // present a request at the current PC
        S_WAIT  = 2'd1,   // request granted, waiting for read data
        S_HOLD  = 2'd2    // instruction presented, waiting for decode
    } state_t;

    localparam logic [XLEN-1:0] C_PC_STEP    = XLEN'(4);
    // Instructions are word aligned; a redirect target has its low bits cleared.
    localparam logic [XLEN-1:0] C_ALIGN_MASK = ~XLEN'(3);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t          state_q,        state_d;
    logic [XLEN-1:0] pc_q,           pc_d;
    logic            drop_q,         drop_d;
    logic            out_valid_q,    out_valid_d;
    logic [XLEN-1:0] out_instr_q,    out_instr_d;
    logic [XLEN-1:0] out_pc_q,       out_pc_d;
    logic [XLEN-1:0] out_pc_plus4_q, out_pc_plus4_d;

    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_redirect_pc;

    // Sequential PC increment wraps naturally at 2^XLEN.
    assign w_pc_plus4    = pc_q + C_PC_STEP;
    assign w_redirect_pc = redirect_pc & C_ALIGN_MASK;

    // ------------------------------------------------------------------------
    // Output drive: request only from FETCH, never while a redirect lands or
    // while reset is asserted; decode outputs come straight from registers.
    // ------------------------------------------------------------------------
    always_comb begin
        imem_req     = (!rst) && (state_q == S_FETCH) && (!redirect_valid);
        imem_addr    = pc_q;
        out_valid    = out_valid_q;
        out_instr    = out_instr_q;
        out_opcode   = out_instr_q[6:0];
        out_pc       = out_pc_q;
        out_pc_plus4 = out_pc_plus4_q;
    end

    // ------------------------------------------------------------------------
    // Next-state logic: redirect has priority over every other event.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        drop_d         = drop_q;
        out_valid_d    = out_valid_q;
        out_instr_d    = out_instr_q;
        out_pc_d       = out_pc_q;
        out_pc_plus4_d = out_pc_plus4_q;

        if (redirect_valid) begin
            pc_d = w_redirect_pc;
            unique case (state_q)
                S_FETCH: begin
                    // Request suppressed this cycle; next cycle asks for the new PC.
                    state_d = S_FETCH;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        // Stale response arrives together with the redirect: discard it.
                        drop_d  = 1'b0;
                        state_d = S_FETCH;
                    end else begin
                        // Response still in flight: remember to discard it.
                        drop_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                S_HOLD: begin
                    // Flush the held instruction even if decode is accepting it.
                    out_valid_d = 1'b0;
                    state_d     = S_FETCH;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (imem_req && imem_gnt) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_FETCH;
                        end else begin
                            out_instr_d    = imem_rdata;
                            out_pc_d       = pc_q;
                            out_pc_plus4_d = w_pc_plus4;
                            out_valid_d    = 1'b1;
                            pc_d           = w_pc_plus4;
                            state_d        = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = S_FETCH;
                    end
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State registers with synchronous reset; reset abandons any request.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_FETCH;
            pc_q           <= RESET_PC;
            drop_q         <= 1'b0;
            out_valid_q    <= 1'b0;
            out_instr_q    <= '0;
            out_pc_q       <= '0;
            out_pc_plus4_q <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            drop_q         <= drop_d;
            out_valid_q    <= out_valid_d;
            out_instr_q    <= out_instr_d;
            out_pc_q       <= out_pc_d;
            out_pc_plus4_q <= out_pc_plus4_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage with a small instruction
//               memory model and an expected-instruction scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [6:0]  out_opcode;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;

    fetch_stage #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_opcode     (out_opcode),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // Memory model state
    logic        fire;
    logic [31:0] faddr;
    bit          pend;
    int          cnt;
    logic [31:0] paddr;
    int          resp_lat;
    bit          poison;
    int          n_fire;
    int          n_hand;

    // Scoreboard of expected {pc, instr} pairs accepted by decode
    logic [63:0] sb_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h0000_0033;
        if (a == 32'h0000_0004) return 32'h0000_0013;
        return {a[24:0], 7'b1101111};
    endfunction

    // One clock: sample outputs at negedge, then update the memory model.
    task automatic tick();
        logic [63:0] exp;
        @(negedge clk);
        fire  = imem_req && imem_gnt;
        faddr = imem_addr;
        if (fire) n_fire++;
        if (!rst && out_valid && out_ready && !redirect_valid) begin
            n_hand++;
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_extra got pc=%h instr=%h want none", out_pc, out_instr);
            end else begin
                exp = sb_q.pop_front();
                if (out_pc !== exp[63:32] || out_instr !== exp[31:0] ||
                    out_pc_plus4 !== exp[63:32] + 32'd4 || out_opcode !== exp[6:0]) begin
                    bad++;
                    $display("FAIL sb_item got pc=%h instr=%h pc4=%h op=%h want pc=%h instr=%h",
                             out_pc, out_instr, out_pc_plus4, out_opcode, exp[63:32], exp[31:0]);
                end
            end
        end
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (fire) begin
            pend  = 1'b1;
            cnt   = resp_lat - 1;
            paddr = faddr;
        end else if (pend && cnt > 0) begin
            cnt--;
        end
        if (pend && cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = poison ? 32'hDEAD_BEEF : mem_word(paddr);
            poison      = 1'b0;
            pend        = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0; resp_lat = 1;
        tick(); tick();
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", imem_req); end
        total++; if ({out_valid, out_instr, out_pc, out_pc_plus4} !== 97'd0) begin
            bad++; $display("FAIL rst_outs got v=%b i=%h pc=%h pc4=%h want all 0", out_valid, out_instr, out_pc, out_pc_plus4); end
        rst = 1'b0;
        #1;
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL t1_req got=%b want=1", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL t1_addr got=%h want=0", imem_addr); end
        sb_q.push_back({32'h0, 32'h0000_0033});
        tick(); tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL t1_valid got=%b want=1", out_valid); end
        total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL t1_pc got=%h want=0", out_pc); end
        total++; if (out_opcode !== 7'b0110011) begin bad++; $display("FAIL t1_opcode got=%b want=0110011", out_opcode); end
        total++; if (out_pc_plus4 !== 32'h4) begin bad++; $display("FAIL t1_pc4 got=%h want=4", out_pc_plus4); end
        tick();
        #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            bad++; $display("FAIL t1_next got req=%b addr=%h want req=1 addr=4", imem_req, imem_addr); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        sb_q.push_back({32'h4, 32'h0000_0013});
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (out_valid !== 1'b1 || out_instr !== 32'h0000_0013) begin
                bad++; $display("FAIL t2_hold[%0d] got v=%b instr=%h want v=1 instr=00000013", i, out_valid, out_instr); end
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL t2_req[%0d] got=%b want=0", i, imem_req); end
            tick();
        end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL t2_still got=%b want=1", out_valid); end
        out_ready = 1'b1;
        tick();
        #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            bad++; $display("FAIL t2_next got req=%b addr=%h want req=1 addr=8", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_wait();
        resp_lat = 3;
        poison   = 1'b1;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL t3_wait got req=%b v=%b want req=0 v=0", imem_req, out_valid); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t3_rv got v=%b want=0", out_valid); end
        resp_lat = 1;
        tick();
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t3_drop got v=%b instr=%h want v=0", out_valid, out_instr); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            bad++; $display("FAIL t3_addr got req=%b addr=%h want req=1 addr=100", imem_req, imem_addr); end
        sb_q.push_back({32'h100, mem_word(32'h100)});
        tick(); tick();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr === 32'hDEAD_BEEF) begin
            bad++; $display("FAIL t3_next got v=%b pc=%h instr=%h want v=1 pc=100", out_valid, out_pc, out_instr); end
        tick();
    endtask

    task automatic test_redirect_hold();
        tick(); tick();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h104) begin
            bad++; $display("FAIL t4_held got v=%b pc=%h want v=1 pc=104", out_valid, out_pc); end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0203; out_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t4_flush got v=%b want=0", out_valid); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            bad++; $display("FAIL t4_addr got req=%b addr=%h want req=1 addr=200", imem_req, imem_addr); end
        sb_q.push_back({32'h200, mem_word(32'h200)});
        tick(); tick();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h200) begin
            bad++; $display("FAIL t4_next got v=%b pc=%h want v=1 pc=200", out_valid, out_pc); end
        tick();
    endtask

    task automatic test_grant_stall();
        int h0;
        int f0;
        imem_gnt = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL t5_suppress got=%b want=0", imem_req); end
        h0 = n_hand;
        f0 = n_fire;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) imem_gnt = 1'b1;
            #1;
            total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
                bad++; $display("FAIL t5_stall[%0d] got req=%b addr=%h want req=1 addr=40", i, imem_req, imem_addr); end
            if (i == 3) sb_q.push_back({32'h40, mem_word(32'h40)});
            tick();
        end
        tick();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h40) begin
            bad++; $display("FAIL t5_out got v=%b pc=%h want v=1 pc=40", out_valid, out_pc); end
        tick();
        total++; if (n_hand - h0 !== 1 || n_fire - f0 !== 1) begin
            bad++; $display("FAIL t5_count got hand=%0d req=%0d want 1 1", n_hand - h0, n_fire - f0); end
        #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h44) begin
            bad++; $display("FAIL t5_next got req=%b addr=%h want req=1 addr=44", imem_req, imem_addr); end
    endtask

    task automatic test_wrap_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL t6_addr got req=%b addr=%h want req=1 addr=fffffffc", imem_req, imem_addr); end
        sb_q.push_back({32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)});
        tick(); tick();
        total++; if (out_pc !== 32'hFFFF_FFFC || out_pc_plus4 !== 32'h0) begin
            bad++; $display("FAIL t6_wrap got pc=%h pc4=%h want pc=fffffffc pc4=0", out_pc, out_pc_plus4); end
        tick();
        #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            bad++; $display("FAIL t6_next got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0500;
        tick();
        redirect_valid = 1'b0;
        resp_lat = 3;
        tick();
        rst = 1'b1; imem_gnt = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL t6_rstreq got=%b want=0", imem_req); end
        tick();
        rst = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t6_rstv got=%b want=0", out_valid); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            bad++; $display("FAIL t6_rstpc got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); end
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
                bad++; $display("FAIL t6_late[%0d] got v=%b req=%b addr=%h want v=0 req=1 addr=0", i, out_valid, imem_req, imem_addr); end
        end
        resp_lat = 1;
        imem_gnt = 1'b1;
        sb_q.push_back({32'h0, 32'h0000_0033});
        tick(); tick();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h0000_0033) begin
            bad++; $display("FAIL t6_after got v=%b pc=%h instr=%h want v=1 pc=0 instr=00000033", out_valid, out_pc, out_instr); end
        tick();
    endtask

    initial begin
        total = 0; bad = 0; n_fire = 0; n_hand = 0;
        pend = 1'b0; cnt = 0; paddr = '0; poison = 1'b0; resp_lat = 1;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
        test_reset();
        test_backpressure();
        test_redirect_wait();
        test_redirect_hold();
        test_grant_stall();
        test_wrap_reset();
        total++; if (sb_q.size() != 0) begin bad++; $display("FAIL sb_left got=%0d want=0", sb_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
